// File: rtl/cpu_result_checker.sv
// cpu_result_checker: compares a qualified result stream against a preloaded table.
// Define CPU_RESULT_CHECKER_TRACE_EN for a simulation-only per-compare trace.
module cpu_result_checker #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 4000,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] result,
    input  logic             result_valid,
    input  logic             exp_we,
    input  logic [AW-1:0]    exp_addr,
    input  logic [WIDTH-1:0] exp_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CW-1:0]    err_count,
    output logic [AW-1:0]    first_err_idx,
    output logic [31:0]      cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [31:0]   TO   = 32'(TIMEOUT);

    state_t           state, state_n;
    logic [AW-1:0]    idx, idx_n;
    logic [CW-1:0]    err_n;
    logic [AW-1:0]    ferr_n;
    logic [31:0]      cyc_n, cyc_inc;
    logic             busy_n, done_n, pass_n, tout_n;
    logic             mismatch, last_cmp, hit_to;
    logic [WIDTH-1:0] exp_mem [DEPTH];

    // Table has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (exp_we && state != S_RUN)
            exp_mem[exp_addr] <= exp_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            idx           <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            cycle_count   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            err_count     <= err_n;
            first_err_idx <= ferr_n;
            cycle_count   <= cyc_n;
            busy          <= busy_n;
            done          <= done_n;
            pass          <= pass_n;
            timeout       <= tout_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        err_n    = err_count;
        ferr_n   = first_err_idx;
        cyc_n    = cycle_count;
        busy_n   = busy;
        done_n   = done;
        pass_n   = pass;
        tout_n   = timeout;
        mismatch = 1'b0;
        last_cmp = 1'b0;
        hit_to   = 1'b0;
        cyc_inc  = (cycle_count == '1) ? cycle_count : cycle_count + 32'd1;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_RUN;
                    idx_n   = '0;
                    err_n   = '0;
                    ferr_n  = '0;
                    cyc_n   = '0;
                    tout_n  = 1'b0;
                    pass_n  = 1'b0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                end
            end
            S_RUN: begin
                cyc_n = cyc_inc;
                if (result_valid) begin
                    mismatch = (result != exp_mem[idx]);
                    idx_n    = idx + AW'(1);
                    last_cmp = (idx == LAST);
                    if (mismatch) begin
                        err_n = err_count + CW'(1);
                        if (err_count == '0)
                            ferr_n = idx;
                    end
                end
                hit_to = (cyc_inc == TO);
                // A final compare landing on the timeout cycle wins.
                if (last_cmp || hit_to) begin
                    state_n = S_DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    tout_n  = !last_cmp;
                    pass_n  = last_cmp && (err_n == '0);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

`ifdef CPU_RESULT_CHECKER_TRACE_EN
    always @(posedge clk) begin
        if (!rst && state == S_RUN && result_valid)
            $display("checker idx=%0d result=%0d expected=%0d %s",
                     idx, $signed(result), $signed(exp_mem[idx]),
                     mismatch ? "MISMATCH" : "OK");
        if (!rst && state == S_RUN && state_n == S_DONE)
            $display("checker summary: %s",
                     tout_n ? "TIMEOUT" : (pass_n ? "PASS" : "FAIL"));
    end
`endif

endmodule

// File: tb/tb_cpu_result_checker.sv
// Scoreboard bench for cpu_result_checker: directed cases plus randomized runs
// checked against a cycle-by-cycle outcome model of the check run.
module tb_cpu_result_checker;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int TO = 40;
    localparam int L  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] result = '0;
    logic        result_valid = 1'b0;
    logic        exp_we = 1'b0;
    logic [3:0]  exp_addr = '0;
    logic [31:0] exp_data = '0;
    logic        busy, done, pass, timeout;
    logic [4:0]  err_count;
    logic [3:0]  first_err_idx;
    logic [31:0] cycle_count;

    cpu_result_checker #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .result(result), .result_valid(result_valid),
        .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .first_err_idx(first_err_idx),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit pass;
        bit tout;
        int errs;
        int first;
        int cycles;
        int edge_at;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] mem_m [D];
    bit          v [L];
    logic [31:0] r [L];

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Outcome of a run from the stimulus and the model table.
    function automatic exp_t model();
        exp_t e;
        int k;
        e = '{pass: 0, tout: 0, errs: 0, first: 0, cycles: 0, edge_at: 0};
        k = 0;
        for (int c = 1; c <= L; c++) begin
            if (v[c-1]) begin
                if (r[c-1] != mem_m[k]) begin
                    if (e.errs == 0) e.first = k;
                    e.errs++;
                end
                k++;
                if (k == D) begin
                    e.pass = (e.errs == 0);
                    e.cycles = c;
                    return e;
                end
            end
            if (c == TO) begin
                e.tout = 1;
                e.cycles = c;
                return e;
            end
        end
        return e;
    endfunction

    task automatic fill_match();
        int k = 0;
        for (int i = 0; i < L; i++) begin
            if (v[i] && k < D) begin
                r[i] = mem_m[k];
                k++;
            end else begin
                r[i] = $urandom;
            end
        end
    endtask

    task automatic gen(input int vpct, input int epct);
        for (int i = 0; i < L; i++)
            v[i] = ($urandom_range(99) < vpct);
        fill_match();
        for (int i = 0; i < L; i++)
            if ($urandom_range(99) < epct)
                r[i] = r[i] ^ ($urandom | 32'h1);
    endtask

    task automatic load(input bit rnd);
        for (int a = 0; a < D; a++) begin
            @(negedge clk);
            exp_we = 1'b1;
            exp_addr = 4'(a);
            exp_data = rnd ? $urandom : 32'(a + 1);
            mem_m[a] = exp_data;
        end
        @(negedge clk);
        exp_we = 1'b0;
    endtask

    task automatic run(input bit poke);
        exp_t e;
        e = model();
        @(negedge clk);
        start = 1'b1;
        result_valid = 1'b0;
        exp_we = 1'b0;
        e.edge_at = cyc + 1 + e.cycles;
        sb.push_back(e);
        for (int c = 1; c <= e.cycles; c++) begin
            @(negedge clk);
            if (c == 1) check("busy_after_start", busy, 1);
            start = poke && (c == 3);
            exp_we = poke && (c == 3);
            exp_addr = 4'd15;
            exp_data = 32'hDEAD;
            result_valid = v[c-1];
            result = r[c-1];
        end
        @(negedge clk);
        start = 1'b0;
        exp_we = 1'b0;
        result_valid = 1'b0;
        for (int i = 0; i < 4 && sb.size() != 0; i++)
            @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
    endtask

    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done && !prev_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("pass", pass, e.pass);
                check("timeout", timeout, e.tout);
                check("err_count", err_count, e.errs);
                check("first_err_idx", first_err_idx, e.first);
                check("cycle_count", cycle_count, e.cycles);
                check("busy_at_done", busy, 0);
                check("done_edge", cyc, e.edge_at);
            end
        end
        prev_done = done;
    end

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_first_err_idx"}, first_err_idx, 0);
        check({tag, "_cycle_count"}, cycle_count, 0);
    endtask

    initial begin
        #2 rst = 1'b1;
        #2 check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        load(1'b0);
        for (int i = 0; i < L; i++) v[i] = 1;
        fill_match();
        run(1'b0);

        r[5] = 32'hFFFFFFFB;
        r[9] = 32'h12345678;
        run(1'b0);

        for (int i = 0; i < L; i++) v[i] = (i < 10);
        fill_match();
        run(1'b0);

        for (int i = 0; i < L; i++) v[i] = (i % 2 == 0);
        fill_match();
        run(1'b0);

        for (int i = 0; i < L; i++) v[i] = (i >= 24);
        fill_match();
        run(1'b0);

        for (int i = 0; i < L; i++) v[i] = (i >= 25);
        fill_match();
        run(1'b0);

        // Abandon a run after 7 compares (one bad) with an async reset.
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            start = 1'b0;
            result_valid = 1'b1;
            result = (c == 2) ? 32'hBAD : mem_m[c];
        end
        @(negedge clk);
        result_valid = 1'b0;
        check("pre_reset_err_count", err_count, 1);
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < L; i++) v[i] = 1;
        fill_match();
        run(1'b0);

        run(1'b1);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(2) == 0) load(1'b1);
            gen($urandom_range(100, 45), $urandom_range(12));
            run($urandom_range(1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got stalled want finish");
        $fatal(1);
    end

endmodule
